// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses the combinational instruction memory and
// captures the fetched word into the IF/ID register; computes the next PC.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] ImAddr_o,
  input  logic [31:0] Instr_i,
  input  logic        Stall_i,
  input  logic        Flush_i,
  input  logic [1:0]  NpcOp_i,
  input  logic [31:0] RegData_i,
  output logic [31:0] Instr_o,
  output logic [31:0] PcPlus4_o,
  output logic        Valid_o,
  output logic        AddrErr_o
);

  localparam logic [31:0] LAST_PC = RESET_PC + 32'(IMEM_WORDS * 4) - 32'd4;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic [31:0] pc_plus4;
  logic [31:0] npc;
  npc_op_e     op_eff;
  logic        jr_misaligned;
  logic        squash;

  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    // Redirects are only meaningful when decode holds a real instruction.
    op_eff        = valid_q ? npc_op_e'(NpcOp_i) : NPC_SEQ;
    jr_misaligned = 1'b0;
    npc           = pc_plus4;
    case (op_eff)
      NPC_BR:  npc = pcp4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
      NPC_J:   npc = {pcp4_q[31:28], instr_q[25:0], 2'b00};
      NPC_JR: begin
        npc           = {RegData_i[31:2], 2'b00};
        jr_misaligned = (RegData_i[1:0] != 2'b00);
      end
      default: npc = pc_plus4;
    endcase
    squash = Flush_i || (op_eff != NPC_SEQ);

    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    if (!Stall_i) begin
      pc_d  = npc;
      err_d = jr_misaligned || (npc < RESET_PC) || (npc > LAST_PC);
      if (squash) begin
        instr_d = '0;
        pcp4_d  = '0;
        valid_d = 1'b0;
      end else begin
        instr_d = Instr_i;
        pcp4_d  = pc_plus4;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign ImAddr_o  = pc_q;
  assign Instr_o   = instr_q;
  assign PcPlus4_o = pcp4_q;
  assign Valid_o   = valid_q;
  assign AddrErr_o = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table followed by randomized
// traffic checked against a cycle-level reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam logic [31:0] LAST = 32'h0000_3FFC;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [1:0]  op;
  logic [31:0] rdata;
  logic [31:0] im_addr, instr_i, instr_o, pcp4_o;
  logic        valid_o, err_o;

  logic [31:0] mem [0:1023];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_3000), .IMEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .ImAddr_o(im_addr), .Instr_i(instr_i),
    .Stall_i(stall), .Flush_i(flush), .NpcOp_i(op), .RegData_i(rdata),
    .Instr_o(instr_o), .PcPlus4_o(pcp4_o), .Valid_o(valid_o), .AddrErr_o(err_o)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    logic [31:0] off;
    if (a < BASE || a > LAST || a[1:0] != 2'b00) return 32'h0;
    off = (a - BASE) >> 2;
    return mem[off[9:0]];
  endfunction

  always_comb instr_i = imem(im_addr);

  typedef struct {
    logic        rst, stall, flush;
    logic [1:0]  op;
    logic [31:0] rdata;
    logic [31:0] pc, instr, pcp4;
    logic        valid, err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic s, input logic f, input logic [1:0] o,
                     input logic [31:0] rd, input logic [31:0] pc, input logic [31:0] ins,
                     input logic [31:0] pp4, input logic v, input logic e);
    vec_t t;
    t.rst = r; t.stall = s; t.flush = f; t.op = o; t.rdata = rd;
    t.pc = pc; t.instr = ins; t.pcp4 = pp4; t.valid = v; t.err = e;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] pp4, input logic v, input logic e);
    chk({tag, ".pc"},    im_addr, pc);
    chk({tag, ".instr"}, instr_o, ins);
    chk({tag, ".pcp4"},  pcp4_o, pp4);
    chk({tag, ".valid"}, {31'b0, valid_o}, {31'b0, v});
    chk({tag, ".err"},   {31'b0, err_o}, {31'b0, e});
  endtask

  // Reference model state: what the IF/ID register and PC should hold.
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid, m_err;

  task automatic model_step();
    logic [31:0] target, seq;
    logic        redirect, bad;
    if (rst) begin
      m_pc = BASE; m_instr = 0; m_pp4 = 0; m_valid = 0; m_err = 0;
      return;
    end
    if (stall) begin
      m_err = 0;
      return;
    end
    seq = m_pc + 32'd4;
    target = seq;
    bad = 1'b0;
    redirect = m_valid && (op != 2'd0);
    if (m_valid) begin
      if (op == 2'd1) target = m_pp4 + 32'($signed(m_instr[15:0]) * 4);
      else if (op == 2'd2) target = (m_pp4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
      else if (op == 2'd3) begin
        target = rdata & ~32'd3;
        bad = (rdata % 4) != 0;
      end
    end
    m_err = bad || target < BASE || target > LAST;
    if (flush || redirect) begin
      m_instr = 0; m_pp4 = 0; m_valid = 0;
    end else begin
      m_instr = imem(m_pc); m_pp4 = seq; m_valid = 1;
    end
    m_pc = target;
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; op = 2'd0; rdata = '0;

    for (int unsigned i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
    mem[2] = 32'h1000_0004;   // branch +4 words
    mem[3] = 32'h0800_0C10;   // jump to 0x3040
    mem[7] = 32'h1000_FFF7;   // branch -9 words
    mem[8] = 32'h1000_0002;   // branch +2 words

    add(1,0,0,0,0,           32'h3000, 0,       0,        0, 0);
    add(1,0,0,0,0,           32'h3000, 0,       0,        0, 0);
    add(0,0,0,0,0,           32'h3004, mem[0],  32'h3004, 1, 0);
    add(0,0,0,0,0,           32'h3008, mem[1],  32'h3008, 1, 0);
    add(0,0,0,0,0,           32'h300C, mem[2],  32'h300C, 1, 0);
    add(0,0,0,1,0,           32'h301C, 0,       0,        0, 0);
    add(0,0,0,0,0,           32'h3020, mem[7],  32'h3020, 1, 0);
    add(0,0,0,1,0,           32'h2FFC, 0,       0,        0, 1);
    add(0,0,0,0,0,           32'h3000, 0,       32'h3000, 1, 0);
    add(0,0,0,0,0,           32'h3004, mem[0],  32'h3004, 1, 0);
    add(0,0,0,0,0,           32'h3008, mem[1],  32'h3008, 1, 0);
    add(0,0,0,0,0,           32'h300C, mem[2],  32'h300C, 1, 0);
    add(0,0,0,0,0,           32'h3010, mem[3],  32'h3010, 1, 0);
    add(0,0,0,2,0,           32'h3040, 0,       0,        0, 0);
    add(0,0,0,0,0,           32'h3044, mem[16], 32'h3044, 1, 0);
    add(0,0,0,3,32'h3022,    32'h3020, 0,       0,        0, 1);
    add(0,0,0,0,0,           32'h3024, mem[8],  32'h3024, 1, 0);
    add(0,0,0,3,32'h3020,    32'h3020, 0,       0,        0, 0);
    add(0,0,0,0,0,           32'h3024, mem[8],  32'h3024, 1, 0);
    add(0,1,0,1,0,           32'h3024, mem[8],  32'h3024, 1, 0);
    add(0,1,0,1,0,           32'h3024, mem[8],  32'h3024, 1, 0);
    add(0,1,0,1,0,           32'h3024, mem[8],  32'h3024, 1, 0);
    add(0,0,0,1,0,           32'h302C, 0,       0,        0, 0);
    add(0,0,0,0,0,           32'h3030, mem[11], 32'h3030, 1, 0);
    add(0,0,1,0,0,           32'h3034, 0,       0,        0, 0);
    add(0,0,0,0,0,           32'h3038, mem[13], 32'h3038, 1, 0);
    add(1,1,0,2,0,           32'h3000, 0,       0,        0, 0);
    add(0,0,0,3,32'h3023,    32'h3004, mem[0],  32'h3004, 1, 0);
    add(0,1,1,3,32'h3023,    32'h3004, mem[0],  32'h3004, 1, 0);

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; stall = vq[i].stall; flush = vq[i].flush;
      op = vq[i].op; rdata = vq[i].rdata;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vq[i].pc, vq[i].instr, vq[i].pcp4,
              vq[i].valid, vq[i].err);
    end

    // Random program image: mix of short branches and in-range jumps.
    for (int unsigned i = 0; i < 1024; i++) begin
      r = $urandom();
      if ($urandom_range(0, 1) == 1)
        mem[i] = {r[31:26], 26'(32'h0C00 + $urandom_range(0, 1023))};
      else
        mem[i] = {r[31:16], 16'($urandom_range(0, 64) - 32)};
    end

    m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_err = 0;
    for (int c = 0; c < 400; c++) begin
      rst   = (c == 0) || ($urandom_range(0, 31) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      op    = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'd0;
      if ($urandom_range(0, 7) == 0) rdata = $urandom();
      else rdata = BASE + $urandom_range(0, 4095);
      model_step();
      @(posedge clk); #1;
      chk_all($sformatf("rnd%0d", c), m_pc, m_instr, m_pp4, m_valid, m_err);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
